// File: rtl/dwt_block_ctrl.sv
// Block sequencer for the 8x8 DWT core: streams source rows in, issues whole
// blocks to the core, and drains each result block to the destination memory.
module dwt_block_ctrl #(
   parameter int NUM_BLOCKS = 1024,
   parameter int ADDR_W     = 13,
   parameter int DWT_LAT    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-3:0] blk_cnt,
   output logic              src_rd_en,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [63:0]       src_rdata,
   output logic [63:0]       dwt_inp1, dwt_inp2, dwt_inp3, dwt_inp4,
   output logic [63:0]       dwt_inp5, dwt_inp6, dwt_inp7, dwt_inp8,
   input  logic [63:0]       dwt_outp1, dwt_outp2, dwt_outp3, dwt_outp4,
   input  logic [63:0]       dwt_outp5, dwt_outp6, dwt_outp7, dwt_outp8,
   input  logic              dwt_valid,
   output logic              dst_wr_en,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [63:0]       dst_wdata
);

   localparam logic [ADDR_W-1:0] LAST_RD  = ADDR_W'(8 * NUM_BLOCKS - 1);
   localparam logic [ADDR_W-3:0] LAST_BLK = (ADDR_W-2)'(NUM_BLOCKS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH, FIN} state_t;

   state_t              state_q, state_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                rdv_q, rdv_d;
   logic [2:0]          row_q, row_d;
   logic [63:0]         rbuf_q [7];
   logic [63:0]         rbuf_d [7];
   logic [63:0]         inp_q [8];
   logic [63:0]         inp_d [8];
   logic [DWT_LAT-1:0]  tag_q, tag_d;
   logic [63:0]         obuf_q [7];
   logic [63:0]         obuf_d [7];
   logic                wr_en_q, wr_en_d;
   logic [2:0]          wr_j_q, wr_j_d;
   logic [ADDR_W-1:0]   wptr_q, wptr_d;
   logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
   logic [63:0]         wdata_q, wdata_d;
   logic [ADDR_W-3:0]   blk_q, blk_d;
   logic                err_q, err_d;
   logic [63:0]         outp [8];

   logic start_acc, issue, capture, last_wr;

   assign outp[0] = dwt_outp1;
   assign outp[1] = dwt_outp2;
   assign outp[2] = dwt_outp3;
   assign outp[3] = dwt_outp4;
   assign outp[4] = dwt_outp5;
   assign outp[5] = dwt_outp6;
   assign outp[6] = dwt_outp7;
   assign outp[7] = dwt_outp8;

   assign start_acc = (state_q == IDLE) && start;
   assign issue     = rdv_q && (row_q == 3'd7);
   assign capture   = tag_q[DWT_LAT-1];
   assign last_wr   = wr_en_q && (wr_j_q == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         rdv_q      <= 1'b0;
         row_q      <= '0;
         rbuf_q     <= '{default: '0};
         inp_q      <= '{default: '0};
         tag_q      <= '0;
         obuf_q     <= '{default: '0};
         wr_en_q    <= 1'b0;
         wr_j_q     <= '0;
         wptr_q     <= '0;
         dst_addr_q <= '0;
         wdata_q    <= '0;
         blk_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         rdv_q      <= rdv_d;
         row_q      <= row_d;
         rbuf_q     <= rbuf_d;
         inp_q      <= inp_d;
         tag_q      <= tag_d;
         obuf_q     <= obuf_d;
         wr_en_q    <= wr_en_d;
         wr_j_q     <= wr_j_d;
         wptr_q     <= wptr_d;
         dst_addr_q <= dst_addr_d;
         wdata_q    <= wdata_d;
         blk_q      <= blk_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   if (rd_addr_q == LAST_RD) state_d = FLUSH;
         FLUSH:   if (last_wr && (blk_q == LAST_BLK)) state_d = FIN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == FIN);
   end

   always_comb begin
      rd_en_d    = rd_en_q;
      rd_addr_d  = rd_addr_q;
      row_d      = row_q;
      rbuf_d     = rbuf_q;
      inp_d      = inp_q;
      obuf_d     = obuf_q;
      wr_en_d    = wr_en_q;
      wr_j_d     = wr_j_q;
      wptr_d     = wptr_q;
      dst_addr_d = dst_addr_q;
      wdata_d    = wdata_q;
      blk_d      = blk_q;
      err_d      = err_q;
      rdv_d      = rd_en_q;
      tag_d      = DWT_LAT'({tag_q, issue});

      if (start_acc) begin
         rd_en_d   = 1'b1;
         rd_addr_d = '0;
         row_d     = '0;
         wptr_d    = '0;
         blk_d     = '0;
         err_d     = 1'b0;
      end else if (state_q == FETCH) begin
         if (rd_addr_q == LAST_RD) rd_en_d = 1'b0;
         else                      rd_addr_d = rd_addr_q + 1'b1;
      end

      // Source data lags the strobe by one cycle; row 7 bypasses the buffer
      if (rdv_q) begin
         row_d = row_q + 3'd1;
         if (row_q == 3'd7) begin
            for (int i = 0; i < 7; i++) inp_d[i] = rbuf_q[i];
            inp_d[7] = src_rdata;
         end else begin
            rbuf_d[row_q] = src_rdata;
         end
      end

      // Row 1 goes straight out on the capture edge; rows 2..8 wait in obuf
      if (capture) begin
         for (int i = 0; i < 7; i++) obuf_d[i] = outp[i+1];
         wr_en_d    = 1'b1;
         wr_j_d     = '0;
         dst_addr_d = wptr_q;
         wdata_d    = outp[0];
         wptr_d     = wptr_q + 1'b1;
         if (!dwt_valid) err_d = 1'b1;
      end else if (wr_en_q) begin
         if (wr_j_q != 3'd7) begin
            wr_j_d     = wr_j_q + 3'd1;
            dst_addr_d = wptr_q;
            wdata_d    = obuf_q[wr_j_q];
            wptr_d     = wptr_q + 1'b1;
         end else begin
            wr_en_d = 1'b0;
         end
      end

      if (last_wr) blk_d = blk_q + 1'b1;
   end

   assign err       = err_q;
   assign blk_cnt   = blk_q;
   assign src_rd_en = rd_en_q;
   assign src_addr  = rd_addr_q;
   assign dst_wr_en = wr_en_q;
   assign dst_addr  = dst_addr_q;
   assign dst_wdata = wdata_q;
   assign dwt_inp1  = inp_q[0];
   assign dwt_inp2  = inp_q[1];
   assign dwt_inp3  = inp_q[2];
   assign dwt_inp4  = inp_q[3];
   assign dwt_inp5  = inp_q[4];
   assign dwt_inp6  = inp_q[5];
   assign dwt_inp7  = inp_q[6];
   assign dwt_inp8  = inp_q[7];

endmodule

// File: tb/tb_dwt_block_ctrl.sv
// Bench for dwt_block_ctrl: source memory and identity DWT models, a read-to-write
// scoreboard, and directed runs covering timing, err, mid-run start and reset.
module tb_dwt_block_ctrl;
   localparam int NB  = 1024;
   localparam int AW  = 13;
   localparam int LAT = 5;
   localparam int DONE_OFS = 8 * (NB - 1) + 22;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, err;
   logic [AW-3:0] blk_cnt;
   logic          src_rd_en;
   logic [AW-1:0] src_addr;
   logic [63:0]   src_rdata = '0;
   logic [63:0]   dwt_inp1, dwt_inp2, dwt_inp3, dwt_inp4;
   logic [63:0]   dwt_inp5, dwt_inp6, dwt_inp7, dwt_inp8;
   logic [63:0]   dwt_outp1, dwt_outp2, dwt_outp3, dwt_outp4;
   logic [63:0]   dwt_outp5, dwt_outp6, dwt_outp7, dwt_outp8;
   logic          dwt_valid;
   logic          dst_wr_en;
   logic [AW-1:0] dst_addr;
   logic [63:0]   dst_wdata;
   logic          vkill = 1'b0;

   dwt_block_ctrl #(.NUM_BLOCKS(NB), .ADDR_W(AW), .DWT_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .blk_cnt(blk_cnt), .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
      .dwt_inp1(dwt_inp1), .dwt_inp2(dwt_inp2), .dwt_inp3(dwt_inp3), .dwt_inp4(dwt_inp4),
      .dwt_inp5(dwt_inp5), .dwt_inp6(dwt_inp6), .dwt_inp7(dwt_inp7), .dwt_inp8(dwt_inp8),
      .dwt_outp1(dwt_outp1), .dwt_outp2(dwt_outp2), .dwt_outp3(dwt_outp3), .dwt_outp4(dwt_outp4),
      .dwt_outp5(dwt_outp5), .dwt_outp6(dwt_outp6), .dwt_outp7(dwt_outp7), .dwt_outp8(dwt_outp8),
      .dwt_valid(dwt_valid), .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wdata(dst_wdata)
   );

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   // Low half carries the word address; the scrambled high half exposes lane mixups
   function automatic logic [63:0] word_of(input logic [AW-1:0] n);
      logic [31:0] h;
      h = 32'(n) * 32'h9E37_79B1;
      return {h, 19'd0, n};
   endfunction

   always @(posedge clk) if (src_rd_en) src_rdata <= word_of(src_addr);

   logic [7:0][63:0] st [LAT-1];
   always @(posedge clk) begin
      st[0] <= {dwt_inp8, dwt_inp7, dwt_inp6, dwt_inp5, dwt_inp4, dwt_inp3, dwt_inp2, dwt_inp1};
      for (int i = 1; i < LAT - 1; i++) st[i] <= st[i-1];
   end
   assign {dwt_outp8, dwt_outp7, dwt_outp6, dwt_outp5,
           dwt_outp4, dwt_outp3, dwt_outp2, dwt_outp1} = st[LAT-2];
   assign dwt_valid = ~vkill;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [AW-1:0] sbq [$];
   int            rd_exp = 0;
   int            done_cnt = 0;
   int            done_edge = -1;

   always @(negedge clk) begin
      if (src_rd_en) begin
         chk("src_addr", 64'(src_addr), 64'(rd_exp));
         sbq.push_back(AW'(rd_exp));
         rd_exp++;
      end
      if (dst_wr_en) begin
         if (sbq.size() == 0) begin
            chk("unexpected_write", 64'(dst_addr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [AW-1:0] e;
            e = sbq.pop_front();
            chk("dst_addr", 64'(dst_addr), 64'(e));
            chk("dst_wdata", dst_wdata, word_of(e));
         end
      end
      if (done) begin
         done_cnt++;
         done_edge = ecnt;
      end
   end

   task automatic wait_to(input int k);
      while (ecnt < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_run(output int s);
      @(posedge clk);
      #1;
      rd_exp = 0;
      sbq.delete();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      s = ecnt;
   endtask

   task automatic finish_run(input int s, input string tag, input logic exp_err);
      int dc0;
      dc0 = done_cnt - ((done_edge >= s) ? 1 : 0);
      while (done_cnt == dc0 && ecnt < s + DONE_OFS + 50) @(negedge clk);
      if (done_cnt == dc0) begin
         chk({tag, "_done_timeout"}, 64'(0), 64'(1));
      end else begin
         chk({tag, "_done_time"}, 64'(done_edge - s), 64'(DONE_OFS));
         chk({tag, "_blk_cnt"}, 64'(blk_cnt), 64'(NB));
         chk({tag, "_err"}, 64'(err), 64'(exp_err));
         chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'(0));
         @(negedge clk);
         chk({tag, "_done_pulse"}, 64'(done), 64'(0));
         chk({tag, "_busy_end"}, 64'(busy), 64'(0));
      end
   endtask

   function automatic logic [63:0] any_out();
      return 64'(|{busy, done, err, blk_cnt, src_rd_en, src_addr, dst_wr_en, dst_addr,
                   dst_wdata, dwt_inp1, dwt_inp2, dwt_inp3, dwt_inp4,
                   dwt_inp5, dwt_inp6, dwt_inp7, dwt_inp8});
   endfunction

   initial begin
      int s;
      logic [63:0] ins [8];

      // Power-on reset, then idle: no strobes without a start
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", any_out(), 64'(0));
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_no_read", 64'(src_rd_en), 64'(0));

      // Run 1: full image, block-issue timing, mid-run start ignored
      start_run(s);
      @(negedge clk);
      chk("r1_busy", 64'(busy), 64'(1));
      chk("r1_rd_en", 64'(src_rd_en), 64'(1));
      chk("r1_blk0", 64'(blk_cnt), 64'(0));
      chk("r1_err0", 64'(err), 64'(0));
      wait_to(s + 8);
      @(negedge clk);
      chk("r1_inp8_pre_issue", dwt_inp8, 64'(0));
      wait_to(s + 9);
      @(negedge clk);
      ins = '{dwt_inp1, dwt_inp2, dwt_inp3, dwt_inp4, dwt_inp5, dwt_inp6, dwt_inp7, dwt_inp8};
      for (int i = 0; i < 8; i++) chk($sformatf("r1_blk0_inp%0d", i + 1), ins[i], word_of(AW'(i)));
      wait_to(s + 16);
      @(negedge clk);
      chk("r1_inp1_hold", dwt_inp1, word_of(AW'(0)));
      wait_to(s + 17);
      @(negedge clk);
      ins = '{dwt_inp1, dwt_inp2, dwt_inp3, dwt_inp4, dwt_inp5, dwt_inp6, dwt_inp7, dwt_inp8};
      for (int i = 0; i < 8; i++) chk($sformatf("r1_blk1_inp%0d", i + 1), ins[i], word_of(AW'(8 + i)));
      wait_to(s + 21);
      @(negedge clk);
      chk("r1_blk_cnt_before", 64'(blk_cnt), 64'(0));
      wait_to(s + 22);
      @(negedge clk);
      chk("r1_blk_cnt_after", 64'(blk_cnt), 64'(1));
      wait_to(s + 100);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("r1_midrun_busy", 64'(busy), 64'(1));
      finish_run(s, "r1", 1'b0);

      // Run 2: dwt_valid low only at block 3's capture edge
      start_run(s);
      wait_to(s + 37);
      vkill = 1'b1;
      @(negedge clk);
      chk("r2_err_before", 64'(err), 64'(0));
      wait_to(s + 38);
      vkill = 1'b0;
      @(negedge clk);
      chk("r2_err_set", 64'(err), 64'(1));
      finish_run(s, "r2", 1'b1);

      // Run 3: start clears err; reset during block 5's drain
      start_run(s);
      @(negedge clk);
      chk("r3_err_cleared", 64'(err), 64'(0));
      wait_to(s + 57);
      @(negedge clk);
      chk("r3_drain_active", 64'(dst_wr_en), 64'(1));
      chk("r3_blk_cnt", 64'(blk_cnt), 64'(5));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("r3_async_reset", any_out(), 64'(0));
      sbq.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("r3_post_reset_idle", 64'(busy | dst_wr_en | src_rd_en), 64'(0));

      // Run 4: restart from scratch after the aborted run
      start_run(s);
      @(negedge clk);
      chk("r4_src_addr0", 64'(src_addr), 64'(0));
      chk("r4_blk_cnt0", 64'(blk_cnt), 64'(0));
      finish_run(s, "r4", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
